// File: rtl/codec_reg_seq.sv
// Table-driven I2C codec register sequencer: walks a register ROM and issues one write per entry.
// Optional write-then-readback verification is enabled by defining CODEC_REG_SEQ_READBACK_EN.
module codec_reg_seq #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int START_DELAY = 1000,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT     = 65535,
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  output logic [IW-1:0]            tbl_idx,
  input  logic [ADDR_W+DATA_W-1:0] tbl_data,
  output logic                     i2c_exec,
  output logic                     i2c_rh_wl,
  output logic [ADDR_W-1:0]        i2c_addr,
  output logic [DATA_W-1:0]        i2c_data_w,
  input  logic                     i2c_done,
  input  logic                     i2c_ack,
  input  logic [DATA_W-1:0]        i2c_data_r,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     cfg_err,
  output logic [IW-1:0]            err_idx
);

  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 2;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 2;

  // START_DELAY spans reset release to the first exec cycle, so IDLE and LOAD eat two of it.
  localparam logic [DLY_W-1:0] DLY_END  = DLY_W'((START_DELAY > 3) ? START_DELAY - 2 : 1);
  localparam logic [TO_W-1:0]  TO_END   = TO_W'((TIMEOUT > 1) ? TIMEOUT - 1 : 1);
  localparam logic [IW-1:0]    IDX_LAST = IW'(NUM_REGS - 1);
  localparam logic [3:0]       RTY_MAX  = 4'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DELAY,
    S_LOAD,
    S_EXEC,
    S_WAIT,
`ifdef CODEC_REG_SEQ_READBACK_EN
    S_RD_EXEC,
    S_RD_WAIT,
    S_VERIFY,
`endif
    S_NEXT,
    S_DONE,
    S_FAIL
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      eidx_q, eidx_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [3:0]         rty_q, rty_d;
  logic               fail_now;

`ifdef CODEC_REG_SEQ_READBACK_EN
  logic [DATA_W-1:0]  rdata_q, rdata_d;
`else
  logic               unused_rdata;
  assign unused_rdata = ^i2c_data_r;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      eidx_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dly_q   <= '0;
      to_q    <= '0;
      rty_q   <= '0;
`ifdef CODEC_REG_SEQ_READBACK_EN
      rdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      eidx_q  <= eidx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dly_q   <= dly_d;
      to_q    <= to_d;
      rty_q   <= rty_d;
`ifdef CODEC_REG_SEQ_READBACK_EN
      rdata_q <= rdata_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    eidx_d   = eidx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dly_d    = dly_q;
    to_d     = to_q;
    rty_d    = rty_q;
    fail_now = 1'b0;
`ifdef CODEC_REG_SEQ_READBACK_EN
    rdata_d  = rdata_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        dly_d   = dly_q + DLY_W'(1);
        state_d = S_DELAY;
      end
      S_DELAY: begin
        if (dly_q == DLY_END) begin
          idx_d   = '0;
          rty_d   = '0;
          state_d = S_LOAD;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      S_LOAD: begin
        addr_d  = tbl_data[ADDR_W+DATA_W-1 -: ADDR_W];
        wdata_d = tbl_data[DATA_W-1:0];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // The exec cycle itself counts toward the timeout window.
        to_d    = TO_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i2c_done) begin
          if (i2c_ack) begin
            fail_now = 1'b1;
          end else begin
`ifdef CODEC_REG_SEQ_READBACK_EN
            state_d = S_RD_EXEC;
`else
            state_d = S_NEXT;
`endif
          end
        end else if (to_q == TO_END) begin
          fail_now = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
`ifdef CODEC_REG_SEQ_READBACK_EN
      S_RD_EXEC: begin
        to_d    = TO_W'(1);
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i2c_done) begin
          if (i2c_ack) begin
            fail_now = 1'b1;
          end else begin
            rdata_d = i2c_data_r;
            state_d = S_VERIFY;
          end
        end else if (to_q == TO_END) begin
          fail_now = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_VERIFY: begin
        if (rdata_q == wdata_q) state_d = S_NEXT;
        else                    fail_now = 1'b1;
      end
`endif
      S_NEXT: begin
        rty_d = '0;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_LOAD;
        end
      end
      S_DONE, S_FAIL: begin
        if (cfg_start) begin
          idx_d   = '0;
          eidx_d  = '0;
          rty_d   = '0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Retries resend the entry still held in addr_q/wdata_q.
    if (fail_now) begin
      if (rty_q != RTY_MAX) begin
        rty_d   = rty_q + 4'd1;
        state_d = S_EXEC;
      end else begin
        eidx_d  = idx_q;
        state_d = S_FAIL;
      end
    end
  end

  assign tbl_idx    = idx_q;
  assign i2c_addr   = addr_q;
  assign i2c_data_w = wdata_q;
  assign err_idx    = eidx_q;
  assign cfg_done   = (state_q == S_DONE);
  assign cfg_err    = (state_q == S_FAIL);
  assign cfg_busy   = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);

`ifdef CODEC_REG_SEQ_READBACK_EN
  assign i2c_exec  = (state_q == S_EXEC) || (state_q == S_RD_EXEC);
  assign i2c_rh_wl = (state_q == S_RD_EXEC);
`else
  assign i2c_exec  = (state_q == S_EXEC);
  assign i2c_rh_wl = 1'b0;
`endif

endmodule

// File: tb/tb_codec_reg_seq.sv
// Bench for codec_reg_seq: two instances (MAX_RETRY 2 and 0) driven by I2C driver models.
module tb_codec_reg_seq;
  localparam int N = 4, AW = 8, DW = 8, SD = 10, TO = 50, LAT = 20;
  localparam int MR_A = 2, MR_B = 0, NS = 10;

  typedef struct {
    logic          rh;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            t;
  } rec_t;

  typedef struct {
    logic [N-1:0][3:0] nack;
    bit                exp_err;
    int                exp_idx;
    bit                rnd;
  } scn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a, start_a, exec_a, rh_a, done_a, ack_a, busy_a, cdone_a, cerr_a;
  logic [1:0] idx_a, eidx_a;
  logic [AW+DW-1:0] tdat_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] dw_a, dr_a;
  logic rst_b, start_b, exec_b, rh_b, done_b, ack_b, busy_b, cdone_b, cerr_b;
  logic [1:0] idx_b, eidx_b;
  logic [AW+DW-1:0] tdat_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] dw_b, dr_b;

  logic [AW+DW-1:0] rom_a [N];
  logic [AW+DW-1:0] rom_b [N];
  assign tdat_a = rom_a[idx_a];
  assign tdat_b = rom_b[idx_b];

  codec_reg_seq #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW), .START_DELAY(SD),
                  .MAX_RETRY(MR_A), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst_a), .cfg_start(start_a), .tbl_idx(idx_a), .tbl_data(tdat_a),
    .i2c_exec(exec_a), .i2c_rh_wl(rh_a), .i2c_addr(addr_a), .i2c_data_w(dw_a),
    .i2c_done(done_a), .i2c_ack(ack_a), .i2c_data_r(dr_a), .cfg_busy(busy_a),
    .cfg_done(cdone_a), .cfg_err(cerr_a), .err_idx(eidx_a));

  codec_reg_seq #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW), .START_DELAY(SD),
                  .MAX_RETRY(MR_B), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst_b), .cfg_start(start_b), .tbl_idx(idx_b), .tbl_data(tdat_b),
    .i2c_exec(exec_b), .i2c_rh_wl(rh_b), .i2c_addr(addr_b), .i2c_data_w(dw_b),
    .i2c_done(done_b), .i2c_ack(ack_b), .i2c_data_r(dr_b), .cfg_busy(busy_b),
    .cfg_done(cdone_b), .cfg_err(cerr_b), .err_idx(eidx_b));

  // Driver model A: done LAT cycles after exec; write attempt k on entry e NACKs while k <= nack_a[e].
  int   scn_a = 0, seen_a = 0;
  int   nack_a [N];
  int   wcnt_a [N];
  rec_t log_a [$];
  bit   pend_a = 0, nk_a = 0;
  int   cnt_a = 0;
  logic [DW-1:0] lastw_a = '0, rdv_a = '0;
  initial begin done_a = 0; ack_a = 0; dr_a = '0; end

  always @(negedge clk) begin
    rec_t r;
    int ei;
    done_a = 1'b0;
    ack_a  = 1'b0;
    if (seen_a != scn_a) begin
      seen_a = scn_a;
      for (int i = 0; i < N; i++) wcnt_a[i] = 0;
    end
    if (rst_a) begin
      pend_a = 0;
    end else begin
      if (pend_a) begin
        cnt_a--;
        if (cnt_a == 0) begin
          pend_a = 0; done_a = 1'b1; ack_a = nk_a; dr_a = rdv_a;
        end
      end
      if (exec_a) begin
        r.rh = rh_a; r.a = addr_a; r.d = dw_a; r.t = cyc;
        log_a.push_back(r);
        ei = int'(addr_a[1:0]);
        if (!rh_a) begin
          wcnt_a[ei]++;
          nk_a = (wcnt_a[ei] <= nack_a[ei]);
          lastw_a = dw_a;
        end else begin
          nk_a = 0;
          rdv_a = lastw_a;
        end
        pend_a = 1; cnt_a = LAT;
      end
    end
  end

  // Driver model B: can hang (never done) or corrupt read data.
  bit   hang_b = 1, corrupt_b = 0, pend_b = 0;
  int   cnt_b = 0, nexec_b = 0;
  logic [DW-1:0] lastw_b = '0, rdv_b = '0;
  initial begin done_b = 0; ack_b = 0; dr_b = '0; end

  always @(negedge clk) begin
    done_b = 1'b0;
    ack_b  = 1'b0;
    if (rst_b) begin
      pend_b = 0;
    end else begin
      if (pend_b) begin
        cnt_b--;
        if (cnt_b == 0) begin pend_b = 0; done_b = 1'b1; dr_b = rdv_b; end
      end
      if (exec_b) begin
        nexec_b++;
        if (!rh_b) lastw_b = dw_b;
        else rdv_b = corrupt_b ? 8'h5A : lastw_b;
        pend_b = !hang_b; cnt_b = LAT;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: expected transfer list and outcome from the retry rules applied to nack_a.
  rec_t exp_q [$];
  bit   exp_err;
  int   exp_idx;
  task automatic model_a();
    int fails;
    int wn;
    bit ok;
    rec_t r;
    exp_q.delete(); exp_err = 0; exp_idx = 0;
    for (int i = 0; i < N; i++) begin
      fails = 0; wn = 0;
      forever begin
        r.rh = 1'b0; r.a = rom_a[i][AW+DW-1:DW]; r.d = rom_a[i][DW-1:0]; r.t = 0;
        exp_q.push_back(r);
        wn++;
        ok = (wn > nack_a[i]);
`ifdef CODEC_REG_SEQ_READBACK_EN
        if (ok) begin r.rh = 1'b1; exp_q.push_back(r); end
`endif
        if (ok) break;
        if (fails == MR_A) begin exp_err = 1; exp_idx = i; return; end
        fails++;
      end
    end
  endtask

  task automatic wait_end_a(input string nm);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (cdone_a || cerr_a) break;
    end
    chk({nm, "_finished"}, 32'(k < 3000), 1);
  endtask

  task automatic check_run_a(input string nm, input int base);
    int n;
    n = log_a.size() - base;
    chk({nm, "_nxfer"}, n, exp_q.size());
    for (int j = 0; j < n && j < exp_q.size(); j++) begin
      chk($sformatf("%s_rh%0d", nm, j), 32'(log_a[base+j].rh), 32'(exp_q[j].rh));
      chk($sformatf("%s_addr%0d", nm, j), 32'(log_a[base+j].a), 32'(exp_q[j].a));
      chk($sformatf("%s_data%0d", nm, j), 32'(log_a[base+j].d), 32'(exp_q[j].d));
    end
    chk({nm, "_err"}, 32'(cerr_a), 32'(exp_err));
    chk({nm, "_done"}, 32'(cdone_a), 32'(!exp_err));
    chk({nm, "_busy"}, 32'(busy_a), 0);
    if (exp_err) chk({nm, "_eidx"}, 32'(eidx_a), exp_idx);
  endtask

  task automatic chk_reset_a(input string nm);
    chk({nm, "_busy"}, 32'(busy_a), 0);
    chk({nm, "_done"}, 32'(cdone_a), 0);
    chk({nm, "_err"}, 32'(cerr_a), 0);
    chk({nm, "_exec"}, 32'(exec_a), 0);
    chk({nm, "_idx"}, 32'(idx_a), 0);
    chk({nm, "_addr"}, 32'(addr_a), 0);
    chk({nm, "_wdata"}, 32'(dw_a), 0);
    chk({nm, "_eidx"}, 32'(eidx_a), 0);
  endtask

  task automatic first_exec_a(input string nm);
    int k;
    bit b1;
    b1 = 0;
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) b1 = busy_a;
      if (exec_a) break;
    end
    chk({nm, "_busy_in_delay"}, 32'(b1), 1);
    chk({nm, "_first_exec_cycle"}, k, SD);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    scn_t tbl [NS];
    int   base, k;
    string nm;
    rst_a = 1; rst_b = 1; start_a = 0; start_b = 0;

    tbl[0] = '{nack: 16'h0000, exp_err: 0, exp_idx: 0, rnd: 0};
    tbl[1] = '{nack: 16'h0200, exp_err: 0, exp_idx: 0, rnd: 0};
    tbl[2] = '{nack: 16'h00F0, exp_err: 1, exp_idx: 1, rnd: 0};
    tbl[3] = '{nack: 16'h0002, exp_err: 0, exp_idx: 0, rnd: 0};
    tbl[4] = '{nack: 16'h3000, exp_err: 1, exp_idx: 3, rnd: 0};
    for (int s = 5; s < NS; s++) tbl[s] = '{nack: 16'h0000, exp_err: 0, exp_idx: 0, rnd: 1};

    for (int s = 0; s < NS; s++) begin
      nm = $sformatf("scn%0d", s);
      scn_a = s + 1;
      for (int i = 0; i < N; i++) begin
        nack_a[i] = tbl[s].rnd ? int'($urandom_range(0, 3)) : int'(tbl[s].nack[i]);
        rom_a[i]  = {6'($urandom), 2'(i), 8'($urandom)};
      end
      model_a();
      base = log_a.size();
      if (s == 0) begin
        repeat (3) @(negedge clk);
        chk_reset_a("reset");
        rst_a = 0;
        first_exec_a(nm);
      end else begin
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        chk({nm, "_restart_busy"}, 32'(busy_a), 1);
        chk({nm, "_restart_done"}, 32'(cdone_a), 0);
        chk({nm, "_restart_err"}, 32'(cerr_a), 0);
        chk({nm, "_restart_eidx"}, 32'(eidx_a), 0);
        chk({nm, "_restart_idx"}, 32'(idx_a), 0);
        if (s == 1) begin
          repeat (30) @(negedge clk);
          start_a = 1;
          @(negedge clk);
          start_a = 0;
        end
      end
      wait_end_a(nm);
      check_run_a(nm, base);
      if (!tbl[s].rnd) begin
        chk({nm, "_tbl_err"}, 32'(cerr_a), 32'(tbl[s].exp_err));
        if (tbl[s].exp_err) chk({nm, "_tbl_eidx"}, 32'(eidx_a), tbl[s].exp_idx);
      end
`ifndef CODEC_REG_SEQ_READBACK_EN
      if (s == 0 && log_a.size() > 1)
        chk("scn0_entry_latency", log_a[1].t - log_a[0].t, LAT + 3);
`endif
    end

    // Reset during WAIT_DONE of entry 3, then a full rerun including the start delay.
    scn_a = scn_a + 1;
    for (int i = 0; i < N; i++) begin
      nack_a[i] = 0;
      rom_a[i]  = {6'($urandom), 2'(i), 8'($urandom)};
    end
    model_a();
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (exec_a && idx_a == 2'd3) break;
    end
    chk("rst_reach_entry3", 32'(k < 2000), 1);
    repeat (5) @(negedge clk);
    rst_a = 1;
    @(negedge clk);
    chk_reset_a("midrst");
    scn_a = scn_a + 1;
    base = log_a.size();
    rst_a = 0;
    first_exec_a("midrst");
    wait_end_a("midrst");
    check_run_a("midrst", base);

    // Instance B: a transfer that never completes must fail exactly TIMEOUT cycles after exec.
    for (int i = 0; i < N; i++) rom_b[i] = {6'(i + 8), 2'(i), 8'(8'h11 * (i + 1))};
    rom_b[0][DW-1:0] = 8'hA5;
    hang_b = 1;
    @(negedge clk);
    rst_b = 0;
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (exec_b) break;
    end
    chk("b_first_exec_cycle", k, SD);
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (cerr_b) break;
    end
    chk("b_timeout_cycles", k, TO);
    chk("b_timeout_eidx", 32'(eidx_b), 0);
    chk("b_timeout_done", 32'(cdone_b), 0);
    chk("b_timeout_busy", 32'(busy_b), 0);
    chk("b_timeout_nexec", nexec_b, 1);

    hang_b = 0;
    corrupt_b = 1;
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (cdone_b || cerr_b) break;
    end
    chk("b_second_finished", 32'(k < 3000), 1);
`ifdef CODEC_REG_SEQ_READBACK_EN
    chk("b_readback_err", 32'(cerr_b), 1);
    chk("b_readback_done", 32'(cdone_b), 0);
    chk("b_readback_eidx", 32'(eidx_b), 0);
    chk("b_readback_nexec", nexec_b, 3);
`else
    chk("b_rerun_done", 32'(cdone_b), 1);
    chk("b_rerun_err", 32'(cerr_b), 0);
    chk("b_rerun_nexec", nexec_b, 1 + N);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
